// File: rtl/max16_pkg.sv
// Shared definitions for the lane-valid scanner and the per-lane max datapath.
package max16_pkg;

  localparam int unsigned ScanWidth = 32;
  localparam int unsigned ScanIdxW  = $clog2(ScanWidth);

  typedef enum logic [0:0] {StIdle, StIssue} scan_state_e;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [ScanIdxW-1:0] lsb_index(input logic [ScanWidth-1:0] mask);
    logic [ScanIdxW-1:0] idx;
    idx = '0;
    for (int i = ScanWidth - 1; i >= 0; i--) begin
      if (mask[i]) idx = ScanIdxW'(i);
    end
    return idx;
  endfunction

  function automatic logic [ScanIdxW:0] pop_count(input logic [ScanWidth-1:0] mask);
    logic [ScanIdxW:0] cnt;
    cnt = '0;
    for (int i = 0; i < ScanWidth; i++) begin
      cnt = cnt + (ScanIdxW + 1)'(mask[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/lsb_enc32.sv
// Combinational lowest-set-bit priority encoder with any / single-bit flags.
module lsb_enc32
  import max16_pkg::*;
#(
  parameter int unsigned WIDTH = ScanWidth,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] mask,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             single
);

  always_comb begin
    idx    = IDX_W'(lsb_index(ScanWidth'(mask)));
    any    = |mask;
    // Clearing the lowest set bit leaves zero only if exactly one bit was set.
    single = any && ((mask & (mask - WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/valid_scanner32.sv
// Walks a loaded lane-valid bitmap, emitting set-bit indices lowest first.
// Optional VALID_SCANNER_COUNT_EN adds count_o, the popcount of the loaded bitmap.
module valid_scanner32
  import max16_pkg::*;
#(
  parameter int unsigned WIDTH = ScanWidth,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             zero_mask
`ifdef VALID_SCANNER_COUNT_EN
  ,
  output logic [IDX_W:0]   count_o
`endif
);

  scan_state_e      state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             zero_q, zero_d;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             enc_single;

  lsb_enc32 #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .mask   (mask_q),
    .idx    (enc_idx),
    .any    (enc_any),
    .single (enc_single)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    zero_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_valid) begin
          if (load_mask != '0) begin
            mask_d  = load_mask;
            state_d = StIssue;
          end else begin
            zero_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (out_ready) begin
          mask_d = mask_q & (mask_q - WIDTH'(1));
          if (enc_single || !enc_any) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mask_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    load_ready = (state_q == StIdle);
    out_valid  = (state_q == StIssue);
    out_index  = out_valid ? enc_idx : '0;
    out_last   = out_valid && enc_single;
    zero_mask  = zero_q;
  end

`ifdef VALID_SCANNER_COUNT_EN
  logic [IDX_W:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (state_q == StIdle && load_valid) begin
      count_d = (IDX_W + 1)'(pop_count(ScanWidth'(load_mask)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;
`endif

endmodule

// File: tb/tb_valid_scanner32.sv
// Directed self-checking bench for valid_scanner32.
module tb_valid_scanner32;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_mask;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_index;
  logic        out_last;
  logic        zero_mask;
`ifdef VALID_SCANNER_COUNT_EN
  logic [5:0]  count_o;
`endif

  int n_total;
  int n_bad;

  valid_scanner32 u_dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_mask  (load_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_last   (out_last),
    .zero_mask  (zero_mask)
`ifdef VALID_SCANNER_COUNT_EN
    ,
    .count_o    (count_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [4:0] idx, input logic last);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".index"}, 32'(out_index), 32'(idx));
    chk({tag, ".last"},  32'(out_last),  32'(last));
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_mask  = '0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("rst", 1'b0, 5'd0, 1'b0);
    chk("rst.zero", 32'(zero_mask), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst.load_ready", 32'(load_ready), 32'd1);

    // Two bits at the extremes of the bitmap.
    load_mask = 32'h8000_0001; load_valid = 1'b1; out_ready = 1'b1;
    tick();
    load_valid = 1'b0;
    chk_out("t1.first", 1'b1, 5'd0, 1'b0);
    chk("t1.load_ready", 32'(load_ready), 32'd0);
    tick();
    chk_out("t1.second", 1'b1, 5'd31, 1'b1);
    tick();
    chk_out("t1.idle", 1'b0, 5'd0, 1'b0);
    chk("t1.load_ready_after", 32'(load_ready), 32'd1);
    chk("t1.zero", 32'(zero_mask), 32'd0);

    // Zero mask, then an immediate follow-on load.
    load_mask = 32'h0; load_valid = 1'b1;
    tick();
    chk("t2.zero_pulse", 32'(zero_mask), 32'd1);
    chk("t2.load_ready", 32'(load_ready), 32'd1);
    chk("t2.no_valid", 32'(out_valid), 32'd0);
    load_mask = 32'h4;
    tick();
    load_valid = 1'b0;
    chk("t2.zero_drop", 32'(zero_mask), 32'd0);
    chk_out("t2.idx2", 1'b1, 5'd2, 1'b1);
    tick();
    chk_out("t2.idle", 1'b0, 5'd0, 1'b0);

    // Stall for three cycles with the first index pending.
    load_mask = 32'h14; load_valid = 1'b1; out_ready = 1'b0;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("t3.stall%0d", i), 1'b1, 5'd2, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    chk_out("t3.go2", 1'b1, 5'd2, 1'b0);
    tick();
    chk_out("t3.go4", 1'b1, 5'd4, 1'b1);
    tick();
    chk_out("t3.idle", 1'b0, 5'd0, 1'b0);

    // Full bitmap; a load offered mid-scan must be ignored.
    load_mask = 32'hFFFF_FFFF; load_valid = 1'b1;
    tick();
    load_mask = 32'h0000_0001;
    for (int i = 0; i < 32; i++) begin
      chk_out($sformatf("t4.i%0d", i), 1'b1, 5'(i), i == 31);
      chk($sformatf("t4.ready%0d", i), 32'(load_ready), 32'd0);
      if (i == 31) load_valid = 1'b0;
      tick();
    end
    chk_out("t4.idle", 1'b0, 5'd0, 1'b0);
    chk("t4.load_ready", 32'(load_ready), 32'd1);

    // Asynchronous reset in the middle of a scan.
    load_mask = 32'h00FF_0000; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk_out("t5.i16", 1'b1, 5'd16, 1'b0);
    tick();
    chk_out("t5.i17", 1'b1, 5'd17, 1'b0);
    rst = 1'b1;
    #1;
    chk_out("t5.async", 1'b0, 5'd0, 1'b0);
    chk("t5.async_ready", 32'(load_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    chk_out("t5.post", 1'b0, 5'd0, 1'b0);
    chk("t5.post_ready", 32'(load_ready), 32'd1);
    load_mask = 32'h1; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk_out("t5.reload", 1'b1, 5'd0, 1'b1);
    tick();
    chk_out("t5.done", 1'b0, 5'd0, 1'b0);

`ifdef VALID_SCANNER_COUNT_EN
    load_mask = 32'h0000_0F0F; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t6.count%0d", i), 32'(count_o), 32'd8);
      tick();
    end
    chk("t6.count_idle", 32'(count_o), 32'd8);
    load_mask = 32'h0; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk("t6.count_zero", 32'(count_o), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
